// File: rtl/seq_sequencer.sv
// Multi-cycle instruction sequencer: walks FETCH..PCUPD per instruction and halts on faults.
// Optional RETIRE_COUNT_EN adds a saturating 32-bit retired-instruction counter port.
module seq_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic        instr_valid,
  input  logic        imem_error,
  input  logic        mem_ready,
  input  logic        dmem_error,
  output logic        f_en,
  output logic        d_en,
  output logic        e_en,
  output logic        m_en,
  output logic        w_en,
  output logic        pc_en,
  output logic        cc_en,
  output logic [1:0]  stat,
  output logic        busy
`ifdef RETIRE_COUNT_EN
  ,
  output logic [31:0] retire_cnt
`endif
);

  localparam logic [1:0] StatAok = 2'd0;
  localparam logic [1:0] StatHlt = 2'd1;
  localparam logic [1:0] StatAdr = 2'd2;
  localparam logic [1:0] StatIns = 2'd3;

  localparam logic [3:0] IcodeHalt = 4'd0;
  localparam logic [3:0] IcodeOpq  = 4'd6;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExecute,
    StMemory,
    StWriteback,
    StPcupd,
    StHalt
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] stat_q, stat_d;
  logic [3:0] icode_q, icode_d;
  logic [3:0] wait_q, wait_d;
  logic       is_mem_op;

  // Instructions that touch data memory and must wait for mem_ready.
  always_comb begin
    is_mem_op = 1'b0;
    case (icode_q)
      4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11: is_mem_op = 1'b1;
      default:                              is_mem_op = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    icode_d = icode_q;
    wait_d  = wait_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        icode_d = icode;
        if (imem_error) begin
          state_d = StHalt;
          stat_d  = StatAdr;
        end else if (!instr_valid) begin
          state_d = StHalt;
          stat_d  = StatIns;
        end else if (icode == IcodeHalt) begin
          state_d = StHalt;
          stat_d  = StatHlt;
        end else begin
          state_d = StDecode;
        end
      end
      StDecode: state_d = StExecute;
      StExecute: begin
        state_d = StMemory;
        wait_d  = 4'd0;
      end
      StMemory: begin
        if (!is_mem_op) begin
          state_d = StWriteback;
        end else if (mem_ready) begin
          if (dmem_error) begin
            state_d = StHalt;
            stat_d  = StatAdr;
          end else begin
            state_d = StWriteback;
          end
        end else if (wait_q == 4'hF) begin
          // Sixteenth cycle without a response: treat as an address fault.
          state_d = StHalt;
          stat_d  = StatAdr;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      StWriteback: state_d = StPcupd;
      StPcupd:     state_d = StFetch;
      StHalt:      state_d = StHalt;
      default:     state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      stat_q  <= StatAok;
      icode_q <= 4'd0;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      icode_q <= icode_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    f_en  = 1'b0;
    d_en  = 1'b0;
    e_en  = 1'b0;
    m_en  = 1'b0;
    w_en  = 1'b0;
    pc_en = 1'b0;
    cc_en = 1'b0;
    busy  = 1'b1;
    case (state_q)
      StFetch:     f_en = 1'b1;
      StDecode:    d_en = 1'b1;
      StExecute: begin
        e_en  = 1'b1;
        cc_en = (icode_q == IcodeOpq);
      end
      StMemory:    m_en  = 1'b1;
      StWriteback: w_en  = 1'b1;
      StPcupd:     pc_en = 1'b1;
      default:     busy  = 1'b0;
    endcase
  end

  assign stat = stat_q;

`ifdef RETIRE_COUNT_EN
  logic [31:0] retire_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      retire_q <= 32'd0;
    end else if (state_q == StPcupd && retire_q != 32'hFFFF_FFFF) begin
      retire_q <= retire_q + 32'd1;
    end
  end

  assign retire_cnt = retire_q;
`endif

  enables_onehot0_a: assert property (@(posedge clk) disable iff (reset)
    $onehot0({f_en, d_en, e_en, m_en, w_en, pc_en}));

  halt_stat_a: assert property (@(posedge clk) disable iff (reset)
    (state_q == StHalt) |-> (stat_q != StatAok));

endmodule

// File: tb/tb_seq_sequencer.sv
// Randomized bench for seq_sequencer: a per-instruction phase-schedule model predicts
// every cycle's enables, cc_en, busy and stat (and retire_cnt when RETIRE_COUNT_EN is set).
module tb_seq_sequencer;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  icode;
  logic        instr_valid, imem_error, mem_ready, dmem_error;
  logic        f_en, d_en, e_en, m_en, w_en, pc_en, cc_en, busy;
  logic [1:0]  stat;
`ifdef RETIRE_COUNT_EN
  logic [31:0] retire_cnt;
`endif

  always #5 clk = ~clk;

  seq_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .icode       (icode),
    .instr_valid (instr_valid),
    .imem_error  (imem_error),
    .mem_ready   (mem_ready),
    .dmem_error  (dmem_error),
    .f_en        (f_en),
    .d_en        (d_en),
    .e_en        (e_en),
    .m_en        (m_en),
    .w_en        (w_en),
    .pc_en       (pc_en),
    .cc_en       (cc_en),
    .stat        (stat),
    .busy        (busy)
`ifdef RETIRE_COUNT_EN
    ,
    .retire_cnt  (retire_cnt)
`endif
  );

  // Phases of one instruction as seen from outside; 1..6 are the busy phases.
  localparam int PhIdle = 0, PhFetch = 1, PhDecode = 2, PhExec = 3;
  localparam int PhMem = 4, PhWb = 5, PhPc = 6, PhHalt = 7;

  int          tests_run = 0;
  int          tests_failed = 0;
  int unsigned exp_retire = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_state(input string tag, input int ph, input bit cc, input logic [1:0] st);
    logic [5:0] en;
    logic [9:0] obs, exp;
    en = '0;
    if (ph >= PhFetch && ph <= PhPc) en[6-ph] = 1'b1;
    exp = {en, cc, (ph >= PhFetch && ph <= PhPc), st};
    obs = {f_en, d_en, e_en, m_en, w_en, pc_en, cc_en, busy, stat};
    check_val(tag, 32'(obs), 32'(exp));
`ifdef RETIRE_COUNT_EN
    check_val({tag, "_retire"}, retire_cnt, exp_retire);
`endif
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Randomize every input the current state should ignore.
  task automatic drive_noise();
    start       = 1'b0;
    icode       = 4'($urandom);
    instr_valid = 1'($urandom);
    imem_error  = 1'($urandom);
    mem_ready   = 1'($urandom);
    dmem_error  = 1'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_noise();
    step();
    drive_noise();
    step();
    reset = 1'b0;
    exp_retire = 0;
    check_state("reset", PhIdle, 1'b0, 2'd0);
  endtask

  task automatic begin_run();
    drive_noise();
    step();
    check_state("idle_hold", PhIdle, 1'b0, 2'd0);
    drive_noise();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic halt_hold(input logic [1:0] hst);
    for (int k = 0; k < 3; k++) begin
      check_state("halt", PhHalt, 1'b0, hst);
      drive_noise();
      start = 1'($urandom);
      step();
    end
    start = 1'b0;
  endtask

  // res: 0 = back in FETCH, 1 = halted, 2 = reset mid-MEMORY (now IDLE).
  task automatic run_instr(input logic [3:0] ic, input bit valid, input bit ierr,
                           input int nwait, input bit derr, input bit rst_mid, output int res);
    bit mem_op;
    res = 0;
    check_state("fetch", PhFetch, 1'b0, 2'd0);
    drive_noise();
    icode       = ic;
    instr_valid = valid;
    imem_error  = ierr;
    step();
    if (ierr || !valid || ic == 4'd0) begin
      halt_hold(ierr ? 2'd2 : (!valid ? 2'd3 : 2'd1));
      res = 1;
      return;
    end
    check_state("decode", PhDecode, 1'b0, 2'd0);
    drive_noise();
    step();
    check_state("execute", PhExec, ic == 4'd6, 2'd0);
    drive_noise();
    step();
    mem_op = ic inside {4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11};
    if (!mem_op) begin
      check_state("mem_single", PhMem, 1'b0, 2'd0);
      drive_noise();
      step();
    end else begin
      for (int i = 0; i < 32; i++) begin
        check_state("mem_wait", PhMem, 1'b0, 2'd0);
        drive_noise();
        if (i < nwait) begin
          mem_ready = 1'b0;
          if (rst_mid && i == 0) begin
            reset = 1'b1;
            step();
            reset = 1'b0;
            exp_retire = 0;
            check_state("reset_mid", PhIdle, 1'b0, 2'd0);
            res = 2;
            return;
          end
          step();
          if (i == 15) begin
            halt_hold(2'd2);
            res = 1;
            return;
          end
        end else begin
          mem_ready  = 1'b1;
          dmem_error = derr;
          step();
          if (derr) begin
            halt_hold(2'd2);
            res = 1;
            return;
          end
          break;
        end
      end
    end
    check_state("writeback", PhWb, 1'b0, 2'd0);
    drive_noise();
    step();
    check_state("pcupd", PhPc, 1'b0, 2'd0);
    drive_noise();
    step();
    if (exp_retire != 32'hFFFF_FFFF) exp_retire++;
  endtask

  initial begin
    int res;
    logic [3:0] ic;
    reset = 1'b1;
    drive_noise();
    step();
    do_reset();
    begin_run();
    run_instr(4'd6, 1'b1, 1'b0, 0, 1'b0, 1'b0, res);    // OPq: cc_en on one cycle
    run_instr(4'd5, 1'b1, 1'b0, 3, 1'b0, 1'b0, res);    // three wait cycles
    run_instr(4'd10, 1'b1, 1'b0, 99, 1'b0, 1'b0, res);  // memory timeout -> ADR
    check_val("timeout_halted", 32'(res), 32'd1);
    do_reset();
    begin_run();
    run_instr(4'd3, 1'b0, 1'b1, 0, 1'b0, 1'b0, res);    // ADR beats INS
    do_reset();
    begin_run();
    run_instr(4'd0, 1'b1, 1'b0, 0, 1'b0, 1'b0, res);    // HLT
    do_reset();
    begin_run();
    run_instr(4'd4, 1'b1, 1'b0, 5, 1'b0, 1'b1, res);    // reset during wait
    check_val("reset_mid_res", 32'(res), 32'd2);

    for (int ep = 0; ep < 40; ep++) begin
      do_reset();
      begin_run();
      for (int n = 0; n < 10; n++) begin
        ic = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        run_instr(ic, $urandom_range(0, 9) != 0, $urandom_range(0, 11) == 0,
                  ($urandom_range(0, 7) == 0) ? int'($urandom_range(16, 20))
                                              : int'($urandom_range(0, 5)),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, res);
        if (res != 0) break;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
